// File: rtl/sram_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_arb_pkg
// Purpose  : Shared types and constants for the SRAM access arbiter.
//            Holds the sequencer state enum, the access-owner encoding and
//            the physical SRAM geometry (256K x 16).
// Revision : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    FINISH = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } arb_owner_e;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_dq_pad.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_dq_pad
// Purpose  : Registered tri-state driver for the SRAM data bus plus the read
//            capture registers for both requester ports.
// Ports    : clk, reset    - clock, synchronous active-high reset
//            i_load        - update drive enable / drive data this edge
//            i_oe          - next drive enable (1 = drive io_dq)
//            i_wdata       - next drive data
//            i_cap_en      - capture io_dq into the owner's read register
//            i_cap_owner   - which port's read register captures
//            o_rdata_a/b   - captured read data per port (held)
//            io_dq         - SRAM data pins
// Revision : 1.0 - initial release
// ============================================================================
module sram_dq_pad
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_oe,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_cap_en,
  input  arb_owner_e        i_cap_owner,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  inout  wire  [DATA_W-1:0] io_dq
);

  logic              r_oe;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;

  // Drive enable comes straight from a flop so the bus turns around cleanly.
  assign io_dq     = r_oe ? r_dout : {DATA_W{1'bz}};
  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_oe      <= 1'b0;
      r_dout    <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (i_load) begin
        r_oe   <= i_oe;
        r_dout <= i_wdata;
      end
      if (i_cap_en) begin
        if (i_cap_owner == OWN_B) r_rdata_b <= io_dq;
        else                      r_rdata_a <= io_dq;
      end
    end
  end

endmodule : sram_dq_pad
`default_nettype wire

// File: rtl/sram_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sram_access_arbiter
// Purpose  : Shares one asynchronous 256Kx16 SRAM between a high-priority
//            read-only port A and a read/write port B. Every access runs
//            SETUP -> ACCESS (ACCESS_CYCLES) -> FINISH with registered pins.
//            Port B is forced after STARVE_LIMIT consecutive A grants.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            a_req/a_addr            - port A request (held until a_ack)
//            a_ack/a_rdata           - port A completion pulse / read data
//            b_req/b_we/b_addr       - port B request, direction, address
//            b_wdata/b_be            - port B write data, byte enables
//            b_ack/b_rdata           - port B completion pulse / read data
//            SRAM_*                  - SRAM device pins
// Revision : 1.0 - initial release
// ============================================================================
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4,
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [1:0]        b_be,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam logic [2:0] c_STROBE_LAST = 3'(ACCESS_CYCLES - 1);
  localparam logic [3:0] c_STARVE_MAX  = 4'(STARVE_LIMIT);

  arb_state_e        r_state;
  arb_owner_e        r_owner;
  logic              r_we;
  logic [2:0]        r_strobe_cnt;
  logic [3:0]        r_starve_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_ub_n;
  logic              r_lb_n;
  logic              r_a_ack;
  logic              r_b_ack;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_last_strobe;
  logic              w_pad_load;
  logic              w_pad_oe;
  logic              w_cap_en;

  // Arbitration is only meaningful in IDLE; A has priority unless B has
  // already watched STARVE_LIMIT A grants go by.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (r_state == IDLE) begin
      if (a_req && b_req) begin
        if (r_starve_cnt == c_STARVE_MAX) w_grant_b = 1'b1;
        else                              w_grant_a = 1'b1;
      end else begin
        w_grant_a = a_req;
        w_grant_b = b_req;
      end
    end
  end

  assign w_last_strobe = (r_state == ACCESS) && (r_strobe_cnt == c_STROBE_LAST);
  // Pad drive state changes when an access starts and when FINISH ends it.
  assign w_pad_load    = w_grant_a || w_grant_b || (r_state == FINISH);
  assign w_pad_oe      = w_grant_b && b_we;
  assign w_cap_en      = w_last_strobe && !r_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_A;
      r_we         <= 1'b0;
      r_strobe_cnt <= '0;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!b_req) r_starve_cnt <= '0;
          if (w_grant_b) begin
            r_state      <= SETUP;
            r_owner      <= OWN_B;
            r_we         <= b_we;
            r_addr       <= b_addr;
            r_ce_n       <= 1'b0;
            r_ub_n       <= b_we ? ~b_be[1] : 1'b0;
            r_lb_n       <= b_we ? ~b_be[0] : 1'b0;
            r_starve_cnt <= '0;
          end else if (w_grant_a) begin
            r_state <= SETUP;
            r_owner <= OWN_A;
            r_we    <= 1'b0;
            r_addr  <= a_addr;
            r_ce_n  <= 1'b0;
            r_ub_n  <= 1'b0;
            r_lb_n  <= 1'b0;
            if (b_req && (r_starve_cnt != c_STARVE_MAX))
              r_starve_cnt <= r_starve_cnt + 4'd1;
          end
        end
        SETUP: begin
          r_state      <= ACCESS;
          r_strobe_cnt <= '0;
          if (r_we) r_we_n <= 1'b0;
          else      r_oe_n <= 1'b0;
        end
        ACCESS: begin
          if (w_last_strobe) begin
            r_state <= FINISH;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            if (r_owner == OWN_B) r_b_ack <= 1'b1;
            else                  r_a_ack <= 1'b1;
          end else begin
            r_strobe_cnt <= r_strobe_cnt + 3'd1;
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_ce_n  <= 1'b1;
          r_ub_n  <= 1'b1;
          r_lb_n  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sram_dq_pad #(
    .DATA_W (DATA_W)
  ) u_dq_pad (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_pad_load),
    .i_oe        (w_pad_oe),
    .i_wdata     (b_wdata),
    .i_cap_en    (w_cap_en),
    .i_cap_owner (r_owner),
    .o_rdata_a   (a_rdata),
    .o_rdata_b   (b_rdata),
    .io_dq       (SRAM_DQ)
  );

  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign SRAM_ADDR = r_addr;
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_UB_N = r_ub_n;
  assign SRAM_LB_N = r_lb_n;

endmodule : sram_access_arbiter
`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sram_access_arbiter
// Purpose  : Self-checking bench for sram_access_arbiter with an SRAM pin
//            model, a transaction-level reference model and directed plus
//            randomized requester traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_access_arbiter;
  import sram_arb_pkg::*;

  localparam int AC = 2;
  localparam int SL = 4;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req;
  logic [AW-1:0] a_addr;
  logic          a_ack;
  logic [DW-1:0] a_rdata;
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [1:0]    b_be;
  logic          b_ack;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] SRAM_ADDR;
  wire  [DW-1:0] SRAM_DQ;
  logic          SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_access_arbiter #(
    .ACCESS_CYCLES (AC),
    .STARVE_LIMIT  (SL),
    .ADDR_W        (AW),
    .DATA_W        (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_addr    (a_addr),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_be      (b_be),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N)
  );

  // ---------------- SRAM device model ----------------
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] sram_rd;
  int            sr_we_low = 0;
  logic [AW-1:0] sr_wa;
  logic [DW-1:0] sr_wd;
  logic          sr_ub, sr_lb;

  assign sram_rd = sram_mem[SRAM_ADDR];
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_rd : 16'bz;

  // A write lands only if WE_N stayed low for the full strobe width.
  initial begin
    forever begin
      @(negedge clk);
      if (!SRAM_CE_N && !SRAM_WE_N) begin
        sr_we_low = sr_we_low + 1;
        sr_wa = SRAM_ADDR; sr_wd = SRAM_DQ; sr_ub = SRAM_UB_N; sr_lb = SRAM_LB_N;
      end else if (sr_we_low != 0) begin
        if (sr_we_low >= AC) begin
          if (!sr_ub) sram_mem[sr_wa][15:8] = sr_wd[15:8];
          if (!sr_lb) sram_mem[sr_wa][7:0]  = sr_wd[7:0];
        end
        sr_we_low = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] gmem [0:(1<<AW)-1];
  int            cyc = 0;
  bit            model_on = 1'b0;
  bit            m_busy = 1'b0;
  int            m_t0, m_d, m_starve;
  bit            m_b, m_wr, m_ga, m_gb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [1:0]    m_be;
  logic          e_ce_n, e_oe_n, e_we_n, e_ub_n, e_lb_n, e_dq_oe, e_a_ack, e_b_ack, e_b_rchk;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_a_rdata, e_b_rdata;

  // Transaction view: a grant in IDLE cycle t gives SETUP at t+1,
  // strobe t+2..t+AC+1, FINISH/ack at t+AC+2, next IDLE at t+AC+3.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (m_busy && m_wr && cyc == m_t0 + AC + 2) begin
        if (m_be[1]) gmem[m_addr][15:8] = m_wd[15:8];
        if (m_be[0]) gmem[m_addr][7:0]  = m_wd[7:0];
      end
      if (reset) begin
        m_busy = 1'b0; m_starve = 0; e_a_rdata = '0; e_b_rdata = '0;
      end else begin
        if (m_busy && !m_wr && cyc == m_t0 + AC + 2) begin
          if (m_b) e_b_rdata = gmem[m_addr];
          else     e_a_rdata = gmem[m_addr];
        end
        if (m_busy && cyc >= m_t0 + AC + 4) m_busy = 1'b0;
        if (!m_busy) begin
          m_gb = b_req && (!a_req || m_starve == SL);
          m_ga = a_req && !m_gb;
          if (!b_req || m_gb) m_starve = 0;
          else if (m_ga && m_starve < SL) m_starve = m_starve + 1;
          if (m_ga || m_gb) begin
            m_busy = 1'b1; m_t0 = cyc - 1; m_b = m_gb; m_wr = m_gb && b_we;
            m_addr = m_gb ? b_addr : a_addr; m_wd = b_wdata; m_be = b_be;
          end
        end
      end
      m_d = m_busy ? cyc - m_t0 : 0;
      e_ce_n = 1; e_oe_n = 1; e_we_n = 1; e_ub_n = 1; e_lb_n = 1;
      e_dq_oe = 0; e_a_ack = 0; e_b_ack = 0; e_b_rchk = 0; e_addr = m_addr;
      if (m_d >= 1 && m_d <= AC + 2) begin
        e_ce_n  = 0;
        e_ub_n  = m_wr ? ~m_be[1] : 1'b0;
        e_lb_n  = m_wr ? ~m_be[0] : 1'b0;
        e_dq_oe = m_wr;
        if (m_d >= 2 && m_d <= AC + 1) begin
          if (m_wr) e_we_n = 0; else e_oe_n = 0;
        end
        if (m_d == AC + 2) begin
          e_a_ack = !m_b; e_b_ack = m_b; e_b_rchk = m_b && !m_wr;
        end
      end
      model_on = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        chk("ce_n",    32'(SRAM_CE_N), 32'(e_ce_n));
        chk("oe_n",    32'(SRAM_OE_N), 32'(e_oe_n));
        chk("we_n",    32'(SRAM_WE_N), 32'(e_we_n));
        chk("ub_n",    32'(SRAM_UB_N), 32'(e_ub_n));
        chk("lb_n",    32'(SRAM_LB_N), 32'(e_lb_n));
        chk("a_ack",   32'(a_ack),     32'(e_a_ack));
        chk("b_ack",   32'(b_ack),     32'(e_b_ack));
        chk("a_rdata", 32'(a_rdata),   32'(e_a_rdata));
        chk("dq_oe",   32'(dut.u_dq_pad.r_oe), 32'(e_dq_oe));
        chk("starve",  32'(dut.r_starve_cnt),  32'(m_starve));
        if (!e_ce_n)  chk("addr",    32'(SRAM_ADDR), 32'(e_addr));
        if (e_dq_oe)  chk("dq",      32'(SRAM_DQ),   32'(m_wd));
        if (e_b_rchk) chk("b_rdata", 32'(b_rdata),   32'(e_b_rdata));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single B transaction from an IDLE cycle; returns edges until b_ack.
  task automatic b_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [1:0] be, output int lat, output logic [DW-1:0] rd,
                       output int we_lo, output logic [1:0] ublb, output bit dq_ok);
    b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    lat = 0; we_lo = 0; ublb = 2'b11; dq_ok = 1;
    do begin
      tick();
      lat = lat + 1;
      if (!SRAM_WE_N) we_lo = we_lo + 1;
      if (lat == 2) ublb = {SRAM_UB_N, SRAM_LB_N};
      if (we && SRAM_DQ !== wd) dq_ok = 0;
    end while (!b_ack && lat < 40);
    if (!b_ack) chk("b_txn_timeout", 32'(lat), 32'(AC + 2));
    rd = b_rdata;
    tick();
    b_req = 0;
  endtask

  int            lat, we_lo, n, a_at, b_at, nack;
  logic [DW-1:0] rd;
  logic [1:0]    ublb;
  bit            dq_ok, a_prev, b_prev;
  logic [5:0]    seq;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin sram_mem[i] = '0; gmem[i] = '0; end
    reset = 1; a_req = 0; a_addr = '0; b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    repeat (3) tick();
    chk("rst_ce_n", 32'(SRAM_CE_N), 1); chk("rst_oe_n", 32'(SRAM_OE_N), 1);
    chk("rst_we_n", 32'(SRAM_WE_N), 1); chk("rst_ub_n", 32'(SRAM_UB_N), 1);
    chk("rst_lb_n", 32'(SRAM_LB_N), 1); chk("rst_addr", 32'(SRAM_ADDR), 0);
    chk("rst_acks", 32'({a_ack, b_ack}), 0); chk("rst_rdata", 32'({a_rdata, b_rdata}), 0);
    chk("rst_dq_oe", 32'(dut.u_dq_pad.r_oe), 0);
    reset = 0;
    tick();

    // 1: full write, then read back
    b_txn(1, 18'h00010, 16'hBEEF, 2'b11, lat, rd, we_lo, ublb, dq_ok);
    chk("t1_lat", 32'(lat), 4); chk("t1_we_lo", 32'(we_lo), 2);
    chk("t1_ublb", 32'(ublb), 0); chk("t1_dq", 32'(dq_ok), 1);
    b_txn(0, 18'h00010, 16'h0000, 2'b11, lat, rd, we_lo, ublb, dq_ok);
    chk("t1_rd", 32'(rd), 32'hBEEF); chk("t1_rlat", 32'(lat), 4);

    // 2: lower-byte-only write over 0xAAAA
    b_txn(1, 18'h00020, 16'hAAAA, 2'b11, lat, rd, we_lo, ublb, dq_ok);
    b_txn(1, 18'h00020, 16'h1234, 2'b01, lat, rd, we_lo, ublb, dq_ok);
    chk("t2_ublb", 32'(ublb), 32'b10);
    b_txn(0, 18'h00020, 16'h0000, 2'b11, lat, rd, we_lo, ublb, dq_ok);
    chk("t2_rd", 32'(rd), 32'hAA34);

    // 3: simultaneous requests
    a_req = 1; a_addr = 18'h00010; b_req = 1; b_we = 0; b_addr = 18'h00020;
    n = 0; a_at = 0; b_at = 0; a_prev = 0;
    while (b_at == 0 && n < 40) begin
      tick(); n = n + 1;
      if (a_prev) a_req = 0;
      a_prev = a_ack;
      if (a_ack) a_at = n;
      if (b_ack) begin b_at = n; rd = b_rdata; end
    end
    chk("t3_a_at", 32'(a_at), 4); chk("t3_b_at", 32'(b_at), 9);
    chk("t3_a_rd", 32'(a_rdata), 32'hBEEF); chk("t3_b_rd", 32'(rd), 32'hAA34);
    tick(); b_req = 0; a_req = 0;
    tick();

    // 4: A streaming against a waiting B
    a_req = 1; a_addr = 18'h00020; b_req = 1; b_we = 0; b_addr = 18'h00010;
    n = 0; nack = 0; seq = '0; b_prev = 0;
    while (nack < 6 && n < 80) begin
      tick(); n = n + 1;
      if (b_prev) b_req = 0;
      b_prev = b_ack;
      if (a_ack) nack = nack + 1;
      if (b_ack) begin
        seq[nack] = 1'b1; nack = nack + 1;
        chk("t4_starve_after_b", 32'(dut.r_starve_cnt), 0);
      end
    end
    chk("t4_order", 32'(seq), 32'b010000);
    tick(); a_req = 0; b_req = 0;
    repeat (3) tick();

    // 5: reset in the first strobe cycle of a write
    b_req = 1; b_we = 1; b_addr = 18'h00030; b_wdata = 16'h5555; b_be = 2'b11;
    repeat (2) tick();
    chk("t5_strobe", 32'(SRAM_WE_N), 0);
    reset = 1;
    tick();
    chk("t5_ctrl", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}), 32'b11111);
    chk("t5_dq_oe", 32'(dut.u_dq_pad.r_oe), 0); chk("t5_b_ack", 32'(b_ack), 0);
    reset = 0; b_req = 0;
    repeat (2) tick();
    b_txn(0, 18'h00030, 16'h0000, 2'b11, lat, rd, we_lo, ublb, dq_ok);
    chk("t5_no_write", 32'(rd), 0);

    // 6: idle bus
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t6_ce_n", 32'(SRAM_CE_N), 1); chk("t6_acks", 32'({a_ack, b_ack}), 0);
      chk("t6_dq_oe", 32'(dut.u_dq_pad.r_oe), 0); chk("t6_starve", 32'(dut.r_starve_cnt), 0);
    end

    // Random traffic
    a_prev = 0; b_prev = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (reset) reset = 0;
      else if ($urandom_range(0, 599) == 0) reset = 1;
      if (a_prev) begin
        if ($urandom_range(0, 2) != 0) a_addr = 18'($urandom_range(0, 31));
        else a_req = 0;
      end else if (!a_req && $urandom_range(0, 3) == 0) begin
        a_req = 1; a_addr = 18'($urandom_range(0, 31));
      end
      a_prev = a_ack;
      if (b_prev || (!b_req && $urandom_range(0, 2) == 0)) begin
        b_req   = (b_prev && $urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = 18'($urandom_range(0, 31));
        b_wdata = 16'($urandom);
        b_be    = 2'($urandom_range(0, 3));
      end
      b_prev = b_ack;
    end
    a_req = 0; b_req = 0; reset = 0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sram_access_arbiter
`default_nettype wire
